// File: rtl/uart_xmtr.sv
// uart_xmtr -- queued 8N1 serial transmitter with clear-to-send flow control.
//
// Bytes offered on tx_data/tx_valid are accepted into a small FIFO whenever
// tx_ready is high. A framer pulls the oldest byte whenever it is idle (or
// has just finished a stop bit) and the remote side asserts uart_cts, then
// shifts out start bit, 8 data bits LSB first and a stop bit, each held for
// CLKS_PER_BIT clocks. Back-to-back frames run with no idle gap.
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous active-low reset
//   tx_data     byte to queue
//   tx_valid    tx_data is valid this cycle
//   tx_ready    queue has room (decoded from the registered count)
//   uart_cts    remote receiver ready; only looked at when a frame may start
//   uart_tx     serial line, flop driven, idles high
//   tx_busy     a frame is in progress
//   fifo_count  bytes currently queued
//
// uart_xmtr_checker (same file) holds the property checks on the outputs.

module uart_xmtr #(
  parameter int CLKS_PER_BIT = 54,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  input  logic                          uart_cts,
  output logic                          uart_tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CNTW-1:0] count_nxt;
  logic            push;
  logic            pop;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   bit_cnt;
  logic [CW-1:0]   bit_cnt_nxt;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_idx_nxt;
  logic [7:0]      shift;
  logic [7:0]      shift_nxt;
  logic            tx_nxt;
  logic            bit_end;
  logic            can_start;

  // Room is judged from the registered count only, so a pop in the same
  // cycle never opens the queue combinationally.
  assign tx_ready  = (fifo_count < CNTW'(FIFO_DEPTH));
  assign push      = tx_valid & tx_ready;
  assign bit_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));
  assign can_start = (fifo_count != {CNTW{1'b0}}) & uart_cts;

  // Queue storage and write pointer; pointer wraps naturally (power-of-2 depth).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wr_ptr <= {AW{1'b0}};
    end else if (push) begin
      mem[wr_ptr] <= tx_data;
      wr_ptr      <= wr_ptr + AW'(1);
    end
  end

  // Read pointer and occupancy count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= {AW{1'b0}};
      fifo_count <= {CNTW{1'b0}};
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count <= count_nxt;
    end
  end

  // Occupancy update: push and pop together leave the count unchanged.
  always_comb begin
    count_nxt = fifo_count;
    case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNTW'(1);
      2'b01:   count_nxt = fifo_count - CNTW'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Framer state, bit timers, shift register and the line/busy flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= {CW{1'b0}};
      bit_idx <= 3'd0;
      shift   <= 8'h00;
      uart_tx <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      uart_tx <= tx_nxt;
      tx_busy <= (state_nxt != IDLE);
    end
  end

  // Framer next-state: tx_nxt is the value the line holds after this edge,
  // so each branch states the bit that must appear from the next cycle on.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = 1'b1;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (can_start) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          state_nxt   = START;
          bit_cnt_nxt = {CW{1'b0}};
          tx_nxt      = 1'b0;
        end else begin
          tx_nxt = 1'b1;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = {CW{1'b0}};
          bit_idx_nxt = 3'd0;
          tx_nxt      = shift[0];
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      DATA: begin
        // The current data bit always sits in shift[0].
        tx_nxt = shift[0];
        if (bit_end) begin
          bit_cnt_nxt = {CW{1'b0}};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      STOP: begin
        tx_nxt = 1'b1;
        if (bit_end) begin
          bit_cnt_nxt = {CW{1'b0}};
          if (can_start) begin
            // Chain straight into the next frame with no idle bit time.
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CW'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        bit_cnt_nxt = {CW{1'b0}};
        bit_idx_nxt = 3'd0;
        tx_nxt      = 1'b1;
      end
    endcase
  end

endmodule

// uart_xmtr_checker -- property checks on uart_xmtr outputs.
// Ports mirror the corresponding uart_xmtr signals.
module uart_xmtr_checker #(
  parameter int FIFO_DEPTH = 4
) (
  input logic                        clock,
  input logic                        reset,
  input logic                        tx_ready,
  input logic                        uart_tx,
  input logic                        tx_busy,
  input logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  a_ready_full: assert property (@(posedge clock) disable iff (!reset)
    !tx_ready |-> (fifo_count == CNTW'(FIFO_DEPTH)));

  a_idle_high: assert property (@(posedge clock) disable iff (!reset)
    !tx_busy |-> uart_tx);

  a_count_max: assert property (@(posedge clock) disable iff (!reset)
    fifo_count <= CNTW'(FIFO_DEPTH));

endmodule

// File: tb/tb_uart_xmtr.sv
// tb_uart_xmtr -- self-checking bench for uart_xmtr.
// A frame-level model (queue + elapsed-time-in-frame) predicts every output
// each cycle; a line decoder recovers bytes from uart_tx; directed sections
// pin literal waveforms, latencies, flow control and reset behaviour.
module tb_uart_xmtr;

  localparam int CPB   = 54;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic                    clock;
  logic                    reset;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    uart_cts;
  logic                    uart_tx;
  logic                    tx_busy;
  logic [$clog2(DEPTH):0]  fifo_count;

  uart_xmtr #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_cts(uart_cts), .uart_tx(uart_tx),
    .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  uart_xmtr_checker #(.FIFO_DEPTH(DEPTH)) chk (
    .clock(clock), .reset(reset), .tx_ready(tx_ready), .uart_tx(uart_tx),
    .tx_busy(tx_busy), .fifo_count(fifo_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];       // bytes waiting
  bit         m_busy;
  int         m_e;         // cycles elapsed in current frame
  logic [7:0] m_byte;
  bit         m_acc;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_busy = 1'b0;
      m_e    = 0;
    end else begin
      m_acc = tx_valid && (mq.size() < DEPTH);
      if (m_busy && m_e < FRAME - 1) begin
        m_e++;
      end else if (mq.size() != 0 && uart_cts) begin
        m_byte = mq.pop_front();
        m_busy = 1'b1;
        m_e    = 0;
      end else begin
        m_busy = 1'b0;
      end
      if (m_acc) mq.push_back(tx_data);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_e / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  int busy_run = 0;
  int last_run = 0;

  // per-cycle comparison against the model
  always @(negedge clock) begin
    check("cyc_uart_tx", uart_tx, exp_tx());
    check("cyc_tx_busy", tx_busy, m_busy);
    check("cyc_fifo_count", fifo_count, mq.size());
    check("cyc_tx_ready", tx_ready, (mq.size() < DEPTH));
    if (tx_busy) busy_run++;
    else begin
      if (busy_run != 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  // ---------------- line decoder ----------------
  logic [7:0] rx_log[$];
  bit         rx_act;
  int         rx_t;
  logic [7:0] rx_sh;
  logic       rx_prev;

  always @(negedge clock) begin
    if (!reset) begin
      rx_act  = 1'b0;
      rx_prev = 1'b1;
    end else begin
      if (!rx_act) begin
        if (uart_tx == 1'b0 && rx_prev == 1'b1) begin
          rx_act = 1'b1;
          rx_t   = 0;
        end
      end else begin
        rx_t++;
        if (rx_t % CPB == CPB / 2 && rx_t >= CPB) begin
          if (rx_t / CPB <= 8) begin
            rx_sh[rx_t / CPB - 1] = uart_tx;
          end else begin
            check("rx_stop_bit", uart_tx, 1'b1);
            rx_log.push_back(rx_sh);
            rx_act = 1'b0;
          end
        end
      end
      rx_prev = uart_tx;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] sent[$];

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_err++;
      $display("FAIL push_timeout data=%02h ready=%0b required=1", b, tx_ready);
    end else begin
      sent.push_back(b);
    end
    @(negedge clock);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input bit need_empty);
    int n;
    n = 0;
    repeat (2) @(negedge clock);
    while ((tx_busy || (need_empty && fifo_count != 0)) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    n_checks++;
    if (n >= 20000) begin
      n_err++;
      $display("FAIL idle_timeout busy=%0b count=%0d required idle", tx_busy, fifo_count);
    end
    @(negedge clock);
  endtask

  logic [9:0] a5_frame;
  logic [7:0] six[6];
  int         mism;
  int         lows;
  bit         ok;
  logic [7:0] d;
  int         gap;

  initial begin
    a5_frame = 10'b1101001010;
    six      = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'h81, 8'h3C};
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    uart_cts = 1'b1;
    reset    = 1'b1;
    #1 reset = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_ready", tx_ready, 1'b1);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check("no_spurious_start", uart_tx, 1'b1);

    // single byte 0xA5: latency, literal waveform, busy length
    rx_log.delete();
    push_byte(8'hA5);
    @(negedge clock);
    check("a5_latency", uart_tx, 1'b0);
    mism = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (uart_tx !== a5_frame[c / CPB]) mism++;
      @(negedge clock);
    end
    check("a5_waveform_mismatches", mism, 0);
    wait_done(1'b1);
    check("a5_busy_cycles", last_run, 540);
    check("a5_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("a5_rx_byte", rx_log[0], 8'hA5);

    // six consecutive pushes, queue fills, back-to-back frames
    rx_log.delete();
    for (int i = 0; i < 5; i++) push_byte(six[i]);
    check("six_count_full", fifo_count, 4);
    check("six_ready_low", tx_ready, 1'b0);
    push_byte(six[5]);
    wait_done(1'b1);
    check("six_busy_cycles", last_run, 3240);
    check("six_rx_count", rx_log.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < rx_log.size()) check("six_rx_byte", rx_log[i], six[i]);
    end

    // clear-to-send gating
    rx_log.delete();
    uart_cts = 1'b0;
    push_byte(8'h12);
    push_byte(8'h34);
    check("cts_count_held", fifo_count, 2);
    repeat (100) @(negedge clock);
    check("cts_line_idle", uart_tx, 1'b1);
    uart_cts = 1'b1;
    @(negedge clock);
    check("cts_start_next_edge", uart_tx, 1'b0);
    repeat (3 * CPB) @(negedge clock);
    uart_cts = 1'b0;
    wait_done(1'b0);
    check("cts_remaining", fifo_count, 1);
    repeat (200) @(negedge clock);
    check("cts_hold_line", uart_tx, 1'b1);
    check("cts_hold_busy", tx_busy, 1'b0);
    check("cts_first_rx_count", rx_log.size(), 1);
    if (rx_log.size() > 0) check("cts_first_rx", rx_log[0], 8'h12);
    uart_cts = 1'b1;
    wait_done(1'b1);
    check("cts_second_rx_count", rx_log.size(), 2);
    if (rx_log.size() > 1) check("cts_second_rx", rx_log[1], 8'h34);

    // asynchronous reset during data bit 3 of 0xC3
    push_byte(8'hC3);
    push_byte(8'hAA);
    push_byte(8'h55);
    check("rst_mid_queued", fifo_count, 2);
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clock);
    check("c3_bit3", uart_tx, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_uart_tx", uart_tx, 1'b1);
    check("async_fifo_count", fifo_count, 0);
    check("async_tx_ready", tx_ready, 1'b1);
    check("async_tx_busy", tx_busy, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("post_reset_quiet", lows, 0);

    // randomized traffic with gaps and clear-to-send toggling
    sent.delete();
    rx_log.delete();
    for (int i = 0; i < 60; i++) begin
      d   = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(100, 900) : $urandom_range(0, 3);
      uart_cts = ($urandom_range(0, 3) != 0);
      repeat (gap) @(negedge clock);
      uart_cts = 1'b1;
      push_byte(d);
    end
    wait_done(1'b1);
    ok = (rx_log.size() == sent.size());
    for (int i = 0; i < sent.size(); i++) begin
      if (i < rx_log.size() && rx_log[i] !== sent[i]) ok = 1'b0;
    end
    check("loopback_count", rx_log.size(), sent.size());
    check("loopback_sequence", ok, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/uart_xmtr.md
UART_XMTR -- requirements
Module: uart_xmtr

Interface
REQ-001: Parameter CLKS_PER_BIT, default 54, meaning clock cycles each serial bit is held on uart_tx.
REQ-002: Parameter FIFO_DEPTH, default 4, meaning byte entries in the transmit queue; SHALL be a power of 2, at least 2.
REQ-003: clock  input  1  sole clock, all state on rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005: tx_data  input  8  byte to queue for transmission.
REQ-006: tx_valid  input  1  tx_data is valid this cycle.
REQ-007: tx_ready  output  1  queue can accept a byte this cycle.
REQ-008: uart_cts  input  1  remote receiver ready (1 = may start a new frame).
REQ-009: uart_tx  output  1  serial line, registered, idle high.
REQ-010: tx_busy  output  1  a frame is in progress.
REQ-011: fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-012: Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-013: Push: byte accepted at a rising edge iff tx_valid=1 and tx_ready=1; when tx_ready=0, tx_data is not accepted and the sender holds it.
REQ-014: tx_ready SHALL equal (fifo_count < FIFO_DEPTH), derived from registered count only (no dependence on same-cycle pop).
REQ-015: FIFO SHALL be first-in first-out; read/write pointers wrap modulo FIFO_DEPTH.
REQ-016: Simultaneous push and pop SHALL both occur; fifo_count unchanged; push-only +1; pop-only -1.
REQ-017: FSM states IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-018: IDLE -> START when fifo_count != 0 and uart_cts=1: head byte popped into shift register at that edge and uart_tx driven 0 from that edge.
REQ-019: Latency: byte pushed at edge N into empty idle block with uart_cts=1 SHALL produce uart_tx=0 from edge N+1.
REQ-020: START -> DATA after CLKS_PER_BIT cycles; DATA presents bit index 0..7 in order, each CLKS_PER_BIT cycles; DATA -> STOP after bit 7.
REQ-021: STOP lasts CLKS_PER_BIT cycles; at its end, if fifo_count != 0 and uart_cts=1, pop and go directly to START (no idle gap), else IDLE with uart_tx=1.
REQ-022: uart_cts is sampled only at frame-start decisions; deassertion mid-frame SHALL NOT truncate or alter the current frame.
REQ-023: Bit-time counter and bit-index counter SHALL reset at every bit/frame boundary; no drift across back-to-back frames.
REQ-024: uart_tx SHALL be glitch-free (driven directly from a flop).

Reset
REQ-025: While reset=0: state IDLE, uart_tx=1, tx_busy=0, fifo_count=0, tx_ready=1, pointers and counters 0.
REQ-026: Reset assertion mid-frame SHALL force uart_tx=1 immediately (asynchronously) and discard the frame and all queued bytes.
REQ-027: After reset release no frame SHALL start until a new byte is pushed.

Verification
REQ-028: Push 0xA5, uart_cts=1 -> uart_tx: 0 for 54 cycles, then 1,0,1,0,0,1,0,1 each 54 cycles, then 1 for 54; tx_busy=1 for exactly 540 cycles.
REQ-029: Push 0x00,0xFF,0x55,0x0F,0x81,0x3C on consecutive cycles -> fifo_count reaches 4 after 5th accept, tx_ready=0, 6th held until first frame ends; six contiguous frames, 3240 cycles, order preserved.
REQ-030: uart_cts=0, push 0x12,0x34 -> uart_tx stays 1, fifo_count=2; raise uart_cts -> start bit next edge; drop uart_cts during 0x12 data bits -> 0x12 completes, uart_tx idles, 0x34 held until uart_cts=1.
REQ-031: Assert reset during DATA bit 3 of 0xC3 with 2 bytes queued -> uart_tx=1 immediately, fifo_count=0, tx_ready=1, tx_busy=0; after release uart_tx stays 1 for 1000 cycles.
REQ-032: Loopback uart_tx into the team's uart_rcvr, 256 random bytes with random tx_valid gaps -> identical byte sequence, one uart_data_rdy pulse per byte.
REQ-033: Assertions: tx_ready=0 implies fifo_count=FIFO_DEPTH; uart_tx=1 whenever tx_busy=0; fifo_count never exceeds FIFO_DEPTH.
